// File: rtl/inst_loader.sv
// UART byte stream -> framed program load into instruction memory; holds the CPU while loading; 1-cycle write after each 4th byte.
// rx_ready drops only during the write cycle; optional inter-byte timeout under LOADER_TIMEOUT_EN.
module inst_loader #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  START_BYTE  = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHK    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        take;
  logic [15:0] len_full;
  logic [15:0] wcnt_inc;

  assign rx_ready  = (state_q != S_WRITE);
  assign take      = rx_valid & rx_ready;
  assign len_full  = {len_q[15:8], rx_data};
  assign wcnt_inc  = wcnt_q + 16'd1;

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_active;
  logic        tmo_hit;

  assign tmo_active = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign tmo_hit    = tmo_active && !take && (tmo_q == 32'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    xor_d   = xor_q;
    word_d  = word_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Only a start marker begins a frame; all other bytes are dropped here.
        if (take && (rx_data == START_BYTE)) begin
          state_d = S_LEN_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          xor_d   = '0;
          addr_d  = BASE_ADDR;
        end
      end
      S_LEN_HI: begin
        if (take) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (take) begin
          len_d = len_full;
          if (32'(len_full) > 32'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          word_d = {word_q[23:0], rx_data};
          xor_d  = xor_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 32'd4;
        wcnt_d  = wcnt_inc;
        state_d = (wcnt_inc == len_q) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (take) begin
          if (rx_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    tmo_d = '0;
    if (tmo_hit) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      hold_d  = 1'b1;
    end else if (tmo_active && !take) begin
      tmo_d = tmo_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      xor_q   <= xor_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (default build): frames, errors, noise, backpressure, async reset.
module tb_inst_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_err;
  int n_chk;
  int rdy_low;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  inst_loader dut (
    .clk       (clk),
    .rst       (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem_we and rx_ready are held for a whole cycle, so one negedge sample per cycle.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (!rx_ready) rdy_low = rdy_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wa_at(input int i);
    return (wa.size() > i) ? wa[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    return (wd.size() > i) ? wd[i] : 32'hDEAD_BEEF;
  endfunction

  // Called at a negedge; returns at the negedge after the byte transferred, rx_valid left high.
  task automatic send(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rdy_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic two_word_frame(input logic [7:0] csum);
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h3C); send(8'h01); send(8'h70); send(8'h00);
    send(8'h3C); send(8'h02); send(8'h70); send(8'h00);
    send(csum);
    idle();
  endtask

  initial begin
    n_err    = 0;
    n_chk    = 0;
    rdy_low  = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rx_ready",  32'(rx_ready),  32'd1);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);
    chk("rst_cpu_hold",  32'(cpu_hold),  32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err",  32'(load_err),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Noise in IDLE is discarded
    send(8'h11); send(8'h22); idle();
    chk("noise_hold", 32'(cpu_hold), 32'd0);
    chk("noise_done", 32'(load_done), 32'd0);
    chk("noise_writes", 32'(wa.size()), 32'd0);

    // Good frame with rx_valid continuously high
    wa.delete(); wd.delete();
    send(8'hA5);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    rdy_low = 0;
    send(8'h00); send(8'h02);
    send(8'h3C); send(8'h01); send(8'h70); send(8'h00);
    send(8'h3C); send(8'h02); send(8'h70); send(8'h00);
    send(8'h03);
    idle();
    chk("good_nwrites", 32'(wa.size()), 32'd2);
    chk("good_addr0", wa_at(0), 32'h0000_0000);
    chk("good_data0", wd_at(0), 32'h3C01_7000);
    chk("good_addr1", wa_at(1), 32'h0000_0004);
    chk("good_data1", wd_at(1), 32'h3C02_7000);
    chk("good_rdy_low", 32'(rdy_low), 32'd2);
    chk("good_done", 32'(load_done), 32'd1);
    chk("good_hold", 32'(cpu_hold), 32'd0);
    chk("good_err",  32'(load_err), 32'd0);
    chk("good_next_addr", mem_addr, 32'h0000_0008);

    // Bad checksum: writes still occur, frame fails
    wa.delete(); wd.delete();
    two_word_frame(8'h04);
    chk("bad_nwrites", 32'(wa.size()), 32'd2);
    chk("bad_data1", wd_at(1), 32'h3C02_7000);
    chk("bad_err",  32'(load_err), 32'd1);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_done", 32'(load_done), 32'd0);

    // Recovery from ERR
    wa.delete(); wd.delete();
    two_word_frame(8'h03);
    chk("rec_addr0", wa_at(0), 32'h0000_0000);
    chk("rec_done", 32'(load_done), 32'd1);
    chk("rec_err",  32'(load_err), 32'd0);

    // Length 1025 > DEPTH
    wa.delete(); wd.delete();
    send(8'hA5); send(8'h04); send(8'h01); idle();
    chk("len_err",  32'(load_err), 32'd1);
    chk("len_hold", 32'(cpu_hold), 32'd1);
    chk("len_done", 32'(load_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("len_nwrites", 32'(wa.size()), 32'd0);

    // Zero length frame
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); idle();
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);
    chk("zero_nwrites", 32'(wa.size()), 32'd0);

    // Start marker inside DATA is plain data
    wa.delete(); wd.delete();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hA5); send(8'hA5); send(8'hA5); send(8'hA5);
    send(8'h00); idle();
    chk("a5data_word", wd_at(0), 32'hA5A5_A5A5);
    chk("a5data_done", 32'(load_done), 32'd1);

    // Asynchronous reset mid-frame
    wa.delete(); wd.delete();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h3C); send(8'h01);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold",  32'(cpu_hold), 32'd0);
    chk("arst_addr",  mem_addr,      32'h0);
    chk("arst_wdata", mem_wdata,     32'h0);
    chk("arst_ready", 32'(rx_ready), 32'd1);
    chk("arst_done",  32'(load_done), 32'd0);
    chk("arst_err",   32'(load_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_nwrites", 32'(wa.size()), 32'd0);
    two_word_frame(8'h03);
    chk("post_rst_addr0", wa_at(0), 32'h0000_0000);
    chk("post_rst_data0", wd_at(0), 32'h3C01_7000);
    chk("post_rst_done",  32'(load_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
